// File: rtl/fib_lookup.sv
// Forwarding lookup: learns SA->port bindings in a 256-entry direct-mapped table and emits a destination mask per DA.
// Optional entry aging is built when FIB_AGE_EN is defined.
module fib_lookup #(
  parameter int NUM_PORTS = 4,
  parameter int TBL_DEPTH = 256,
  parameter int AGE_TICKS = 65536
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 p2f_srdy,
  output logic                 p2f_drdy,
  input  logic [99:0]          p2f_data,
  output logic                 fli_srdy,
  input  logic                 fli_drdy,
  output logic [NUM_PORTS-1:0] fli_data
);

  localparam int ENT_W = 54;
  localparam logic [4:0] NP = 5'(NUM_PORTS);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    DA_RD  = 3'd2,
    SA_RD  = 3'd3,
    OUT    = 3'd4
`ifdef FIB_AGE_EN
    ,
    AGE_RD = 3'd5,
    AGE_WR = 3'd6
`endif
  } state_t;

  function automatic logic [7:0] mac_hash(input logic [47:0] mac);
    return mac[7:0] ^ mac[15:8] ^ mac[23:16] ^ mac[31:24] ^ mac[39:32] ^ mac[47:40];
  endfunction

  // Flood excludes the ingress port only when it names a real port.
  function automatic logic [NUM_PORTS-1:0] dest_mask(
    input logic [3:0]  src,
    input logic [47:0] da,
    input logic        ent_vld,
    input logic [47:0] ent_mac,
    input logic [3:0]  ent_port
  );
    logic [NUM_PORTS-1:0] one;
    logic [NUM_PORTS-1:0] src_bit;
    one     = NUM_PORTS'(1);
    src_bit = ({1'b0, src} < NP) ? (one << src) : '0;
    if (da[40] || !ent_vld || (ent_mac != da)) return ~src_bit;
    else if (ent_port == src) return '0;
    else return one << ent_port;
  endfunction

  state_t            state;
  logic [7:0]        init_cnt;
  logic              accept;
  logic              learn;

  logic [3:0]        src_p0;
  logic [47:0]       sa_p0;
  logic [47:0]       da_p0;
  logic              da_vld_p1;
  logic [47:0]       da_mac_p1;
  logic [3:0]        da_port_p1;

  logic [ENT_W-1:0]  mem [0:TBL_DEPTH-1];
  logic [ENT_W-1:0]  rd_data;
  logic              ram_we;
  logic [7:0]        ram_addr;
  logic [ENT_W-1:0]  ram_wdata;

`ifdef FIB_AGE_EN
  logic [31:0]       age_cnt;
  logic              age_pend;
  logic [7:0]        age_ptr;
`else
  logic              unused_ok;
  assign unused_ok = ^{rd_data[0], AGE_TICKS[0]};
`endif

  assign accept = (state == IDLE) && p2f_drdy && p2f_srdy;
  assign learn  = !sa_p0[40] && ({1'b0, src_p0} < NP);

  // Single table port: one read or write per cycle, chosen by the FSM state.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = init_cnt;
    ram_wdata = '0;
    case (state)
      INIT:  ram_we = 1'b1;
      IDLE:  ram_addr = mac_hash(p2f_data[47:0]);
      DA_RD: ram_addr = mac_hash(sa_p0);
      SA_RD: begin
        ram_addr  = mac_hash(sa_p0);
        ram_we    = learn;
        ram_wdata = {1'b1, sa_p0, src_p0, 1'b1};
      end
`ifdef FIB_AGE_EN
      AGE_RD: ram_addr = age_ptr;
      AGE_WR: begin
        ram_addr  = age_ptr;
        ram_we    = rd_data[53];
        ram_wdata = {rd_data[0], rd_data[52:1], 1'b0};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_data <= mem[ram_addr];
  end

  // Stage p0: record capture; stage p1: DA entry capture
  always_ff @(posedge clk) begin
    if (accept) begin
      src_p0 <= p2f_data[99:96];
      sa_p0  <= p2f_data[95:48];
      da_p0  <= p2f_data[47:0];
    end
    if (state == DA_RD) begin
      da_vld_p1  <= rd_data[53];
      da_mac_p1  <= rd_data[52:5];
      da_port_p1 <= rd_data[4:1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
      p2f_drdy <= 1'b0;
      fli_srdy <= 1'b0;
      fli_data <= '0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 8'd1;
          if (init_cnt == 8'hFF) begin
            state    <= IDLE;
            p2f_drdy <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            p2f_drdy <= 1'b0;
            state    <= DA_RD;
          end
`ifdef FIB_AGE_EN
          else if (age_pend) begin
            p2f_drdy <= 1'b0;
            state    <= AGE_RD;
          end else begin
            p2f_drdy <= 1'b1;
          end
`endif
        end
        DA_RD: state <= SA_RD;
        SA_RD: begin
          fli_data <= dest_mask(src_p0, da_p0, da_vld_p1, da_mac_p1, da_port_p1);
          fli_srdy <= 1'b1;
          state    <= OUT;
        end
        OUT: begin
          if (fli_drdy) begin
            fli_srdy <= 1'b0;
            p2f_drdy <= 1'b1;
            state    <= IDLE;
          end
        end
`ifdef FIB_AGE_EN
        AGE_RD: state <= AGE_WR;
        AGE_WR: begin
          p2f_drdy <= 1'b1;
          state    <= IDLE;
        end
`endif
        default: state <= INIT;
      endcase
    end
  end

`ifdef FIB_AGE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      age_cnt  <= '0;
      age_pend <= 1'b0;
      age_ptr  <= '0;
    end else begin
      if (age_cnt == 32'(AGE_TICKS - 1)) begin
        age_cnt  <= '0;
        age_pend <= 1'b1;
      end else begin
        age_cnt <= age_cnt + 32'd1;
        if (state == AGE_WR) age_pend <= 1'b0;
      end
      if (state == AGE_WR) age_ptr <= age_ptr + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fib_lookup.sv
// Bench for fib_lookup: directed cases plus randomized records checked against a table-level reference model.
module tb_fib_lookup;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          p2f_srdy;
  logic          p2f_drdy;
  logic [99:0]   p2f_data;
  logic          fli_srdy;
  logic          fli_drdy;
  logic [NP-1:0] fli_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit        vld;
    bit [47:0] mac;
    bit [3:0]  port;
  } ent_t;

  ent_t        tbl [256];
  logic [47:0] pool [16];

  fib_lookup #(.NUM_PORTS(NP)) dut (
    .clk(clk), .reset(reset),
    .p2f_srdy(p2f_srdy), .p2f_drdy(p2f_drdy), .p2f_data(p2f_data),
    .fli_srdy(fli_srdy), .fli_drdy(fli_drdy), .fli_data(fli_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_hash(input logic [47:0] m);
    logic [7:0] h;
    h = '0;
    for (int i = 0; i < 6; i++) h ^= m[i*8 +: 8];
    return h;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 256; i++) tbl[i] = '{1'b0, 48'h0, 4'h0};
  endtask

  // Lookup against pre-learn contents, then learn.
  task automatic model_step(input logic [3:0] src, input logic [47:0] sa, input logic [47:0] da,
                            output logic [NP-1:0] m);
    logic [NP-1:0] flood;
    ent_t e;
    flood = '0;
    for (int p = 0; p < NP; p++) if (p != int'(src)) flood[p] = 1'b1;
    e = tbl[ref_hash(da)];
    if (da[40] || !e.vld || e.mac != da) m = flood;
    else if (e.port == src) m = '0;
    else begin
      m = '0;
      m[e.port] = 1'b1;
    end
    if (!sa[40] && int'(src) < NP) tbl[ref_hash(sa)] = '{1'b1, sa, src};
  endtask

  task automatic do_reset(input string tag);
    int n;
    @(negedge clk);
    reset = 1'b1; p2f_srdy = 1'b0; fli_drdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 check({tag, "_rst_out"}, {p2f_drdy, fli_srdy, fli_data}, '0);
    @(negedge clk) reset = 1'b0;
    n = 0;
    while (!p2f_drdy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_init_cycles"}, n, 256);
    clear_model();
  endtask

  task automatic send(input logic [3:0] src, input logic [47:0] sa, input logic [47:0] da, input int hold);
    logic [NP-1:0] exp_m;
    int n;
    int idx;
    model_step(src, sa, da, exp_m);
    @(negedge clk);
    p2f_srdy = 1'b1;
    p2f_data = {src, sa, da};
    n = 0;
    while (!p2f_drdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!p2f_drdy) begin
      check("accept_timeout", 0, 1);
      p2f_srdy = 1'b0;
      return;
    end
    @(posedge clk); #1;
    p2f_srdy = 1'b0;
    p2f_data = {4'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    // idx counts cycles from the transfer cycle (idx 0)
    idx = 1;
    while (!fli_srdy && idx < 20) begin
      @(posedge clk); #1;
      idx++;
    end
    check("latency", idx, 3);
    for (int i = 0; i < hold; i++) begin
      check("hold", {fli_srdy, fli_data, p2f_drdy}, {1'b1, exp_m, 1'b0});
      @(posedge clk); #1;
    end
    check("mask", fli_data, exp_m);
    @(negedge clk) fli_drdy = 1'b1;
    @(posedge clk); #1;
    fli_drdy = 1'b0;
    check("release", {fli_srdy, p2f_drdy}, 2'b01);
  endtask

  initial begin
    logic [3:0]  src;
    logic [47:0] sa;
    logic [47:0] da;
    int n;
    reset = 1'b1; p2f_srdy = 1'b0; fli_drdy = 1'b0; p2f_data = '0;
    for (int i = 0; i < 8; i++) pool[i] = {40'h0, 8'(i)};
    for (int i = 8; i < 16; i++) pool[i] = {32'h0, 8'(i), 8'((i - 8) ^ i)};

    do_reset("boot");

    send(4'd2, 48'h0000_0000_0005, 48'hFFFF_FFFF_FFFF, 0);
    send(4'd1, 48'h0000_0000_0007, 48'h0000_0000_0005, 0);
    send(4'd2, 48'h0000_0000_0009, 48'h0000_0000_0005, 0);
    send(4'd2, 48'h0000_0000_0005, 48'h0000_0000_0007, 0);
    send(4'd3, 48'h0000_0000_0104, 48'h0000_0000_0009, 0);
    send(4'd0, 48'h0000_0000_0011, 48'h0000_0000_0005, 0);
    send(4'd2, 48'h0000_0000_0005, 48'h0000_0000_0104, 0);
    send(4'd1, 48'h0000_0000_0012, 48'h0000_0000_0104, 10);
    send(4'd5, 48'h0000_0000_0022, 48'hFFFF_FFFF_FFFF, 0);
    send(4'd0, 48'h0000_0000_0033, 48'h0000_0000_0022, 0);
    send(4'd3, 48'h0100_0000_0044, 48'h0000_0000_0012, 2);
    send(4'd1, 48'h0000_0000_0055, 48'h0100_0000_0044, 0);

    for (int k = 0; k < 150; k++) begin
      src = 4'($urandom_range(0, 5));
      sa  = pool[$urandom_range(0, 15)];
      da  = pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 9) == 0) da[40] = 1'b1;
      if ($urandom_range(0, 9) == 0) sa[40] = 1'b1;
      send(src, sa, da, $urandom_range(0, 3));
    end

    // Reset while a record is in flight: it is dropped and the table is wiped.
    @(negedge clk);
    p2f_srdy = 1'b1;
    p2f_data = {4'd1, 48'h0000_0000_0055, 48'h0000_0000_0005};
    n = 0;
    while (!p2f_drdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    p2f_srdy = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out", {fli_srdy, p2f_drdy}, 2'b00);
    do_reset("mid");
    send(4'd0, 48'h0000_0000_0066, 48'h0000_0000_0005, 0);
    send(4'd3, 48'h0000_0000_0077, 48'h0000_0000_0007, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
